// File: rtl/mem_uart_bridge_pkg.sv
// Shared types, message lengths and message packing for the CPU-side memory bridge.
package mem_uart_bridge_pkg;
  localparam int MSG_W = 72;
  localparam logic [4:0] LEN_READ  = 5'd5;
  localparam logic [4:0] LEN_WRITE = 5'd9;
  localparam logic [4:0] LEN_RESP  = 5'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  function automatic logic [MSG_W-1:0] pack_read(input logic [31:0] addr);
    pack_read = '0;
    pack_read[31:0] = addr;
  endfunction

  function automatic logic [MSG_W-1:0] pack_write(input logic [31:0] addr, input logic [31:0] wdata,
                                                  input logic [3:0] mask);
    pack_write = '0;
    pack_write[31:0]  = wdata;
    pack_write[63:32] = addr;
    pack_write[67:64] = mask;
  endfunction
endpackage

// File: rtl/mem_uart_bridge_if.sv
// Core-side request port and transport-side message port of the memory bridge.
interface mem_cpu_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_done;

  modport master (output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
                  input  if_rdata, if_done, mem_rdata, mem_done);
  modport slave  (input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
                  output if_rdata, if_done, mem_rdata, mem_done);
endinterface

interface mem_tx_if;
  import mem_uart_bridge_pkg::*;
  logic             tx_ready;
  logic             tx_flag;
  logic [4:0]       tx_length;
  logic [MSG_W-1:0] tx_data;
  logic             rx_valid;
  logic [4:0]       rx_length;
  logic [MSG_W-1:0] rx_data;
  logic             rx_flag;

  modport master (input  tx_ready, rx_valid, rx_length, rx_data,
                  output tx_flag, tx_length, tx_data, rx_flag);
  modport slave  (output tx_ready, rx_valid, rx_length, rx_data,
                  input  tx_flag, tx_length, tx_data, rx_flag);
endinterface

// File: rtl/mem_uart_bridge_rr_arbiter.sv
// Two-way round-robin grant (0 = fetch, 1 = data); last-served updates on commit.
module mem_rr_arbiter
  import mem_uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       commit,
  input  owner_t     commit_id,
  output logic       gnt_vld,
  output owner_t     gnt
);
  owner_t last_q;

  // Data port counts as last served out of reset so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= OWN_MEM;
    else if (commit) last_q <= commit_id;
  end

  always_comb begin
    gnt_vld = |req;
    gnt     = OWN_IF;
    if (req[1] && (!req[0] || last_q == OWN_IF)) gnt = OWN_MEM;
  end
endmodule

// File: rtl/mem_uart_bridge.sv
// Arbitrates fetch/data word requests into 72-bit transport messages and returns read responses.
module mem_uart_bridge
  import mem_uart_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_cpu_if.slave   cpu,
  mem_tx_if.master   xport,
  output logic [7:0] stray_cnt
);
  state_t           state_q, state_d;
  owner_t           owner_q, grant;
  logic             grant_vld;
  logic [MSG_W-1:0] tx_data_q;
  logic [4:0]       tx_len_q;
  logic [31:0]      if_rdata_q, mem_rdata_q;
  logic             skip_q, pop, tx_flag, commit, resp_ok;
  logic [7:0]       stray_q;
  logic [ADDR_W-1:0] sel_addr;
  logic             unused_rx;

  assign unused_rx = ^xport.rx_data[MSG_W-1:32];

  mem_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({cpu.mem_req, cpu.if_req}),
    .commit    (commit),
    .commit_id (owner_q),
    .gnt_vld   (grant_vld),
    .gnt       (grant)
  );

  assign sel_addr = (grant == OWN_MEM) ? cpu.mem_addr : cpu.if_addr;

  // The transport's valid lags a pop by one cycle, so the cycle after a pop is blind.
  assign pop = xport.rx_valid & ~skip_q;

  always_comb begin
    state_d = state_q;
    tx_flag = 1'b0;
    commit  = 1'b0;
    resp_ok = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_vld) state_d = ST_SEND;
      ST_SEND: if (xport.tx_ready) begin
        tx_flag = 1'b1;
        state_d = (tx_len_q == LEN_WRITE) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: if (pop && xport.rx_length == LEN_RESP) begin
        resp_ok = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      tx_data_q   <= '0;
      tx_len_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      skip_q      <= 1'b0;
      stray_q     <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= pop;
      if (state_q == ST_IDLE && grant_vld) begin
        owner_q <= grant;
        if (grant == OWN_MEM && cpu.mem_we) begin
          tx_data_q <= pack_write(sel_addr, cpu.mem_wdata, cpu.mem_mask);
          tx_len_q  <= LEN_WRITE;
        end else begin
          tx_data_q <= pack_read(sel_addr);
          tx_len_q  <= LEN_READ;
        end
      end
      if (resp_ok) begin
        if (owner_q == OWN_MEM) mem_rdata_q <= xport.rx_data[31:0];
        else                    if_rdata_q  <= xport.rx_data[31:0];
      end
      // Any pop that is not the awaited response is dropped and counted.
      if (pop && !resp_ok && stray_q != 8'hFF) stray_q <= stray_q + 8'd1;
    end
  end

  assign xport.tx_flag   = tx_flag;
  assign xport.tx_data   = tx_data_q;
  assign xport.tx_length = tx_len_q;
  assign xport.rx_flag   = pop;
  assign cpu.if_done     = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign cpu.mem_done    = (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign cpu.if_rdata    = if_rdata_q;
  assign cpu.mem_rdata   = mem_rdata_q;
  assign stray_cnt       = stray_q;
endmodule

// File: tb/tb_mem_uart_bridge.sv
// Drives the bridge as core and transport; checks messages, completions and stray counting against a model.
module tb_mem_uart_bridge;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] stray_cnt;
  int         n_chk = 0;
  int         n_err = 0;

  // Reference state: last served port (1 = data), stray count, held read words.
  bit          m_last = 1'b1;
  int          m_stray = 0;
  logic [31:0] m_rd_if = '0, m_rd_mem = '0;

  mem_cpu_if cpu();
  mem_tx_if  xp();

  mem_uart_bridge #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu),
    .xport     (xp),
    .stray_cnt (stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] exp_msg(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] m);
    if (wr) return {4'h0, m, a, d};
    return {40'h0, a};
  endfunction

  // Push one unsolicited message, then hold valid one stale cycle that must be ignored.
  task automatic inject_stray(input logic [4:0] len);
    xp.rx_valid  = 1'b1;
    xp.rx_length = len;
    xp.rx_data   = {8'($urandom), $urandom, $urandom};
    #1;
    chk("stray_pop", xp.rx_flag, 1);
    chk("stray_nodone", {cpu.if_done, cpu.mem_done}, 0);
    if (m_stray < 255) m_stray++;
    @(negedge clk); #1;
    chk("stale_skip", xp.rx_flag, 0);
    chk("stray_cnt", stray_cnt, m_stray);
    xp.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Entered at the negedge of the SEND cycle; leaves at the negedge of the DONE cycle.
  task automatic serve(input bit own_mem, input int dly, input bit stray, input logic [31:0] resp);
    bit          wr;
    logic [71:0] emsg;
    logic [4:0]  slen;
    wr   = own_mem && cpu.mem_we;
    emsg = own_mem ? exp_msg(wr, cpu.mem_addr, cpu.mem_wdata, cpu.mem_mask)
                   : exp_msg(1'b0, cpu.if_addr, '0, '0);
    for (int i = 0; i < dly; i++) begin
      #1;
      chk("tx_hold_flag", xp.tx_flag, 0);
      chk("tx_hold_data", xp.tx_data, emsg);
      @(negedge clk);
    end
    xp.tx_ready = 1'b1;
    #1;
    chk("tx_flag", xp.tx_flag, 1);
    chk("tx_len", xp.tx_length, wr ? 5'd9 : 5'd5);
    chk("tx_data", xp.tx_data, emsg);
    @(negedge clk);
    xp.tx_ready = 1'b0;
    if (!wr) begin
      if (stray) begin
        slen = 5'($urandom);
        if (slen == 5'd4) slen = 5'd9;
        inject_stray(slen);
      end
      xp.rx_valid  = 1'b1;
      xp.rx_length = 5'd4;
      xp.rx_data   = {8'($urandom), $urandom, resp};
      #1;
      chk("rsp_pop", xp.rx_flag, 1);
      chk("rsp_nodone", {cpu.if_done, cpu.mem_done}, 0);
      if (own_mem) m_rd_mem = resp;
      else         m_rd_if  = resp;
      @(negedge clk);
    end
    #1;
    chk("if_done", cpu.if_done, !own_mem);
    chk("mem_done", cpu.mem_done, own_mem);
    chk("done_rx_flag", xp.rx_flag, 0);
    chk("if_rdata", cpu.if_rdata, m_rd_if);
    chk("mem_rdata", cpu.mem_rdata, m_rd_mem);
    chk("stray_cnt", stray_cnt, m_stray);
    xp.rx_valid = 1'b0;
    if (own_mem) cpu.mem_req = 1'b0;
    else         cpu.if_req  = 1'b0;
    m_last = own_mem;
  endtask

  // Entered and left at the negedge of an IDLE cycle; ties are served winner first.
  task automatic round(input bit do_if, input bit do_mem, input bit mem_wr, input logic [31:0] ia,
                       input logic [31:0] ma, input logic [31:0] mw, input logic [3:0] mk,
                       input logic [31:0] resp, input int dly, input bit stray);
    bit first_mem;
    if (do_if) begin cpu.if_req = 1'b1; cpu.if_addr = ia; end
    if (do_mem) begin
      cpu.mem_req = 1'b1; cpu.mem_we = mem_wr; cpu.mem_addr = ma;
      cpu.mem_wdata = mw; cpu.mem_mask = mk;
    end
    first_mem = do_mem && (!do_if || !m_last);
    @(negedge clk);
    serve(first_mem, dly, stray, resp);
    @(negedge clk);
    if (do_if && do_mem) begin
      @(negedge clk);
      serve(!first_mem, dly, stray, resp ^ 32'hFFFF_0000);
      @(negedge clk);
    end
  endtask

  initial begin
    bit di, dm;
    cpu.if_req = 0; cpu.if_addr = '0; cpu.mem_req = 0; cpu.mem_we = 0;
    cpu.mem_addr = '0; cpu.mem_wdata = '0; cpu.mem_mask = '0;
    xp.tx_ready = 0; xp.rx_valid = 0; xp.rx_length = '0; xp.rx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_flag", xp.tx_flag, 0);
    chk("rst_tx_len", xp.tx_length, 0);
    chk("rst_tx_data", xp.tx_data, 0);
    chk("rst_rx_flag", xp.rx_flag, 0);
    chk("rst_done", {cpu.if_done, cpu.mem_done}, 0);
    chk("rst_rdata", {cpu.if_rdata, cpu.mem_rdata}, 0);
    chk("rst_stray", stray_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    round(1, 0, 0, 32'h10, '0, '0, '0, 32'hDEAD_BEEF, 0, 0);
    round(0, 1, 1, '0, 32'h104, 32'h41, 4'b0001, '0, 0, 0);
    round(1, 1, 0, 32'h200, 32'h300, '0, '0, 32'h1111_2222, 0, 0);
    round(1, 1, 0, 32'h204, 32'h304, '0, '0, 32'h3333_4444, 1, 0);
    round(1, 0, 0, 32'h400, '0, '0, '0, 32'h5555_6666, 5, 0);
    round(0, 1, 0, '0, 32'h500, '0, '0, 32'h7777_8888, 0, 1);
    inject_stray(5'd9);

    // Reset while waiting for a read response; the late response is a stray.
    cpu.if_req = 1'b1; cpu.if_addr = 32'h600;
    @(negedge clk);
    xp.tx_ready = 1'b1;
    @(negedge clk);
    xp.tx_ready = 1'b0;
    rst = 1'b1; cpu.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_done", {cpu.if_done, cpu.mem_done}, 0);
    chk("mid_rst_stray", stray_cnt, 0);
    chk("mid_rst_tx_flag", xp.tx_flag, 0);
    m_stray = 0; m_last = 1'b1; m_rd_if = '0; m_rd_mem = '0;
    @(negedge clk);
    inject_stray(5'd4);
    round(1, 0, 0, 32'h700, '0, '0, '0, 32'hCAFE_F00D, 0, 0);

    for (int r = 0; r < 30; r++) begin
      di = 1'($urandom);
      dm = 1'($urandom);
      if (!di && !dm) di = 1'b1;
      round(di, dm, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), $urandom,
            $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 3) == 0) inject_stray(5'($urandom));
    end

    for (int s = 0; s < 260; s++) inject_stray(5'($urandom));
    chk("stray_sat", stray_cnt, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_uart_bridge.md
# mem_uart_bridge

CPU-side memory bridge. Accepts word requests from the instruction-fetch port and the data port, arbitrates between them, and packs each request into one 72-bit message on channel 0 of the CPU-side multichannel UART transport. For reads it waits for the 4-byte response and returns it to the requester. It sits between the core's IF/MEM stages and the transport that feeds the simulated memory server.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; fixed at 32 by the message format.

Ports:
- clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- mem_req  in  1  data request; held until mem_done
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data byte address
- mem_wdata  in  32  write data
- mem_mask  in  4  byte enables; bit i enables wdata[8i+7:8i]
- mem_rdata  out  32  read data; valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse
- tx_ready  in  1  transport can accept a message
- tx_flag  out  1  message push strobe
- tx_length  out  5  message length in bytes
- tx_data  out  72  message payload
- rx_valid  in  1  a received message is available
- rx_length  in  5  received message length
- rx_data  in  72  received message payload
- rx_flag  out  1  pop strobe
- stray_cnt  out  8  count of dropped messages; saturates at 255

## Operation
Message formats:
- Read: length 5; data[31:0]=addr; data[39:32]=0; rest 0.
- Write: length 9; data[31:0]=wdata; data[63:32]=addr; data[67:64]=mask; rest 0.
- Response: length 4; data[31:0]=word.

States: IDLE, SEND, WAIT, DONE.
- IDLE: if any req is high, pick an owner and latch its message into tx_data/tx_length, then go to SEND.
- Arbitration: round-robin. When both ports request, the port not served last wins. After reset, the data port is treated as last served, so fetch wins the first tie.
- SEND: tx_flag = (state==SEND) & tx_ready, combinational.
  - On accept of a write: go to DONE.
  - On accept of a read: go to WAIT.
- WAIT: when rx_valid is high, rx_flag=1 for that cycle (the pop).
  - If rx_length==4: latch rx_data[31:0] into the owner's rdata, then go to DONE.
  - Otherwise: drop the message, increment stray_cnt, stay in WAIT.
- DONE: pulse the owner's done for one cycle, update the last-served record, return to IDLE. rdata holds its value until the next read by that port.
- In IDLE, SEND or DONE, any rx_valid is popped (rx_flag=1) and counted as stray.
- Reset values: all outputs 0; state IDLE; rdata registers 0; stray_cnt 0.

## Timing
- Request seen at edge n (IDLE) → SEND in cycle n+1. tx_flag rises in n+1 if tx_ready=1; otherwise the message is held stable until tx_ready rises.
- Write latency with tx_ready=1: done in cycle n+2 (2 cycles).
- Read: response popped in cycle m → done in cycle m+1.
- Back-to-back: a requester may re-assert req in the cycle after done. The earliest new acceptance is the cycle after DONE (IDLE cycle), giving a minimum spacing of 3 cycles per write.
- rx_flag is at most one cycle wide. After any pop, rx_valid is ignored for the following cycle, because the transport's valid updates one cycle late.
- Reset mid-operation: state returns to IDLE, no done is pulsed, and the in-flight tx is abandoned. A response arriving later is popped as stray.
- Requester rule: address, data and mask must be stable from req until done. Dropping req early is illegal; behaviour is unspecified.

## Structure
- Shared package holds:
  - MSG_W=72
  - LEN_READ=5, LEN_WRITE=9, LEN_RESP=4
  - state encoding
  - message-pack functions for read and write
- One sub-module, mem_rr_arbiter: 2-way round-robin grant with a last-served register, updated on a commit strobe.
- Everything else is a single FSM plus datapath registers.

## Test plan
- Fetch read addr 0x00000010, response data 0xDEADBEEF → tx_length=5, tx_data[31:0]=0x10; if_done=1 with if_rdata=0xDEADBEEF one cycle after the pop.
- Write addr 0x104, wdata 0x41, mask 4'b0001, tx_ready=1 → tx_length=9, tx_data[67:32]=0x1_00000104; mem_done 2 cycles after req; no rx_flag.
- if_req and mem_req asserted together and held for 4 transactions → grants alternate IF, MEM, IF, MEM.
- tx_ready held low for 5 cycles → tx_data stable and tx_flag=0 throughout; tx_flag=1 in the cycle tx_ready rises.
- A length-9 message injected while in WAIT, then a valid length-4 response → stray_cnt=1, then a correct done. A message injected while IDLE → popped, stray_cnt=2.
- rst asserted in WAIT, response delivered afterwards → no done pulses; stray_cnt=1 after the pop; the next request completes normally.
